ddr4_dqs_dir_tracker: RTL and testbench



---
 rtl/ddr4_dqs_dir_tracker_pkg.sv | 20 ++
 rtl/ddr4_dqs_dir_tracker_if.sv | 25 ++
 rtl/ddr4_dqs_dir_lane.sv | 119 +++++++++++
 rtl/ddr4_dqs_dir_tracker.sv | 36 +++
 tb/tb_ddr4_dqs_dir_tracker.sv | 130 +++++++++++++
 5 files changed

// File: rtl/ddr4_dqs_dir_tracker_pkg.sv
// rtl/ddr4_dqs_dir_tracker_pkg.sv - shared types and helpers for the DQS direction tracker
package ddr4_dqs_dir_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_ARM = 3'd1,
        ST_WR     = 3'd2,
        ST_RD_ARM = 3'd3,
        ST_RD     = 3'd4,
        ST_GAP    = 3'd5
    } lane_state_e;

    // Only a clean complementary pair counts; X, Z or equal levels are undriven.
    function automatic logic dqs_driven(input logic t, input logic c);
        return ((t === 1'b1) && (c === 1'b0)) || ((t === 1'b0) && (c === 1'b1));
    endfunction

endpackage

// File: rtl/ddr4_dqs_dir_tracker_if.sv
// rtl/ddr4_dqs_dir_tracker_if.sv - DQS sample inputs and per-lane direction outputs
interface ddr4_dqs_dir_tracker_if #(
    parameter int MC_DQS_BITS = 4
);
    logic                   enable;
    logic                   conflict_clr;
    logic [MC_DQS_BITS-1:0] mc_dqs_t;
    logic [MC_DQS_BITS-1:0] mc_dqs_c;
    logic [MC_DQS_BITS-1:0] mem_dqs_t;
    logic [MC_DQS_BITS-1:0] mem_dqs_c;
    logic [MC_DQS_BITS-1:0] wr_drive;
    logic [MC_DQS_BITS-1:0] rd_drive;
    logic [MC_DQS_BITS-1:0] busy;
    logic [MC_DQS_BITS-1:0] conflict;

    modport master (
        output enable, conflict_clr, mc_dqs_t, mc_dqs_c, mem_dqs_t, mem_dqs_c,
        input  wr_drive, rd_drive, busy, conflict
    );

    modport slave (
        input  enable, conflict_clr, mc_dqs_t, mc_dqs_c, mem_dqs_t, mem_dqs_c,
        output wr_drive, rd_drive, busy, conflict
    );
endinterface

// File: rtl/ddr4_dqs_dir_lane.sv
// rtl/ddr4_dqs_dir_lane.sv - one nibble's direction FSM with preamble, postamble and guard counting
module ddr4_dqs_dir_lane
    import ddr4_dqs_dir_pkg::*;
#(
    parameter int PRE_CYCLES  = 2,
    parameter int IDLE_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic conflict_clr,
    input  logic mc_t,
    input  logic mc_c,
    input  logic mem_t,
    input  logic mem_c,
    output logic wr_drive,
    output logic rd_drive,
    output logic busy,
    output logic conflict
);
    localparam logic [CNT_W-1:0] PRE_W  = CNT_W'(PRE_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_W = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] GAP_W  = CNT_W'(GAP_CYCLES);

    lane_state_e       state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
    logic              mc_on, mem_on, own_on, opp_on, conf_set;

    always_comb begin
        mc_on   = dqs_driven(mc_t, mc_c);
        mem_on  = dqs_driven(mem_t, mem_c);
        own_on  = (state == ST_RD_ARM || state == ST_RD) ? mem_on : mc_on;
        opp_on  = (state == ST_RD_ARM || state == ST_RD) ? mc_on : mem_on;
        // cnt_inc counts the current sample too, so thresholds compare against it
        cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
        state_n  = state;
        cnt_n    = cnt;
        conf_set = 1'b0;
        if (!enable) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mc_on && mem_on) begin
                        conf_set = 1'b1;
                    end else if (mc_on || mem_on) begin
                        if (PRE_CYCLES <= 1) begin
                            state_n = mc_on ? ST_WR : ST_RD;
                            cnt_n   = '0;
                        end else begin
                            state_n = mc_on ? ST_WR_ARM : ST_RD_ARM;
                            cnt_n   = {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_WR_ARM, ST_RD_ARM: begin
                    if (opp_on) begin
                        conf_set = 1'b1;
                        state_n  = ST_IDLE;
                        cnt_n    = '0;
                    end else if (!own_on) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else if (cnt_inc >= PRE_W) begin
                        state_n = (state == ST_WR_ARM) ? ST_WR : ST_RD;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                // The opposite side is the delay model's own echo while a direction is held.
                ST_WR, ST_RD: begin
                    if (own_on) begin
                        cnt_n = '0;
                    end else if (cnt_inc >= IDLE_W) begin
                        state_n = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                ST_GAP: begin
                    if (cnt_inc >= GAP_W) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            conflict <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (conf_set)
                conflict <= 1'b1;
            else if (conflict_clr)
                conflict <= 1'b0;
        end
    end

    assign wr_drive = (state == ST_WR);
    assign rd_drive = (state == ST_RD);
    assign busy     = (state != ST_IDLE);
endmodule

// File: rtl/ddr4_dqs_dir_tracker.sv
// rtl/ddr4_dqs_dir_tracker.sv - per-nibble DQS direction tracker driving the data-buffer delay model
module ddr4_dqs_dir_tracker
    import ddr4_dqs_dir_pkg::*;
#(
    parameter int MC_DQS_BITS = 4,
    parameter int PRE_CYCLES  = 2,
    parameter int IDLE_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    ddr4_dqs_dir_tracker_if.slave   bus
);
    for (genvar i = 0; i < MC_DQS_BITS; i++) begin : g_lane
        ddr4_dqs_dir_lane #(
            .PRE_CYCLES  (PRE_CYCLES),
            .IDLE_CYCLES (IDLE_CYCLES),
            .GAP_CYCLES  (GAP_CYCLES),
            .CNT_W       (CNT_W)
        ) u_lane (
            .clk          (clk),
            .reset        (reset),
            .enable       (bus.enable),
            .conflict_clr (bus.conflict_clr),
            .mc_t         (bus.mc_dqs_t[i]),
            .mc_c         (bus.mc_dqs_c[i]),
            .mem_t        (bus.mem_dqs_t[i]),
            .mem_c        (bus.mem_dqs_c[i]),
            .wr_drive     (bus.wr_drive[i]),
            .rd_drive     (bus.rd_drive[i]),
            .busy         (bus.busy[i]),
            .conflict     (bus.conflict[i])
        );
    end
endmodule

// File: tb/tb_ddr4_dqs_dir_tracker.sv
// tb/tb_ddr4_dqs_dir_tracker.sv - directed self-checking bench for ddr4_dqs_dir_tracker
module tb_ddr4_dqs_dir_tracker;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    ddr4_dqs_dir_tracker_if #(.MC_DQS_BITS(N)) bus ();

    ddr4_dqs_dir_tracker #(
        .MC_DQS_BITS (N),
        .PRE_CYCLES  (2),
        .IDLE_CYCLES (4),
        .GAP_CYCLES  (1),
        .CNT_W       (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input int l, input bit mc, input bit mem, input bit use_z);
        bus.mc_dqs_t[l]  = mc  ? 1'b1 : (use_z ? 1'bz : 1'b0);
        bus.mc_dqs_c[l]  = mc  ? 1'b0 : (use_z ? 1'bz : 1'b0);
        bus.mem_dqs_t[l] = mem ? 1'b0 : (use_z ? 1'bz : 1'b0);
        bus.mem_dqs_c[l] = mem ? 1'b1 : (use_z ? 1'bz : 1'b0);
    endtask

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_all(input string ph, input logic [N-1:0] ew, input logic [N-1:0] er,
                           input logic [N-1:0] eb, input logic [N-1:0] ec);
        chk({ph, "_wr_drive"}, bus.wr_drive, ew);
        chk({ph, "_rd_drive"}, bus.rd_drive, er);
        chk({ph, "_busy"},     bus.busy,     eb);
        chk({ph, "_conflict"}, bus.conflict, ec);
    endtask

    function automatic bit in_rng(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    task automatic do_reset;
        reset = 1'b1;
        bus.enable = 1'b1;
        bus.conflict_clr = 1'b0;
        for (int l = 0; l < N; l++) drive(l, 1'b0, 1'b0, 1'b0);
        tick;
        tick;
        reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        logic w012, w3, b012, b3;

        // Reset state
        do_reset;
        chk_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Write burst on lane 0, read with echo on lane 1, contention on lane 2, Z glitch on lane 3
        for (int n = 0; n < 40; n++) begin
            drive(0, in_rng(n, 10, 17), 1'b0, 1'b0);
            drive(1, in_rng(n, 23, 30), in_rng(n, 20, 27), 1'b0);
            drive(2, (n == 5) || (n == 14), (n == 5) || (n == 14), 1'b0);
            drive(3, n == 3, 1'b0, 1'b1);
            bus.conflict_clr = (n == 9) || (n == 14) || (n == 18);
            tick;
            chk_all("p1",
                    {3'b000, in_rng(cyc, 12, 21)},
                    {2'b00, in_rng(cyc, 22, 31), 1'b0},
                    {cyc == 4, 1'b0, in_rng(cyc, 21, 32), in_rng(cyc, 11, 22)},
                    {1'b0, in_rng(cyc, 6, 9) || in_rng(cyc, 15, 18), 2'b00});
        end
        bus.conflict_clr = 1'b0;

        // Turnaround guard: write released at 30, mem driven from 30
        do_reset;
        for (int n = 0; n < 50; n++) begin
            drive(0, in_rng(n, 10, 25), in_rng(n, 30, 40), 1'b0);
            tick;
            chk_all("p2",
                    {3'b000, in_rng(cyc, 12, 29)},
                    {3'b000, in_rng(cyc, 33, 44)},
                    {3'b000, in_rng(cyc, 11, 30) || in_rng(cyc, 32, 45)},
                    4'b0000);
        end

        // Reset mid-burst, re-arm afterwards, then enable low forces idle
        do_reset;
        for (int n = 0; n < 30; n++) begin
            reset = (n == 15);
            bus.enable = (n < 23);
            for (int l = 0; l < 3; l++) drive(l, 1'b1, 1'b0, 1'b0);
            drive(3, 1'b1, n == 0, 1'b0);
            tick;
            w012 = in_rng(cyc, 2, 15) || in_rng(cyc, 18, 23);
            w3   = in_rng(cyc, 3, 15) || in_rng(cyc, 18, 23);
            b012 = in_rng(cyc, 1, 15) || in_rng(cyc, 17, 23);
            b3   = in_rng(cyc, 2, 15) || in_rng(cyc, 17, 23);
            chk_all("p3",
                    {w3, w012, w012, w012},
                    4'b0000,
                    {b3, b012, b012, b012},
                    {in_rng(cyc, 1, 15), 3'b000});
        end
        reset = 1'b0;
        bus.enable = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
